// File: rtl/packet_tx_engine.sv
// Serialises buffered packet slots onto the output link with ready/valid, sop/eop and size checks.
// Define CRC_GEN_EN to replace the stored CRC word with one computed on the fly.
module packet_tx_engine #(
   parameter int                UWIDTH    = 8,
   parameter int                PTR_IN_SZ = 4,
   parameter int                SIZE_BITS = 3,
   parameter int                CNT_W     = 16,
   parameter logic [UWIDTH-1:0] CRC_POLY  = 8'h07
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rempty,
   input  logic [UWIDTH-1:0]    rdata,
   output logic [PTR_IN_SZ-1:0] raddr_in,
   output logic                 rinc,
   output logic [UWIDTH-1:0]    packet_out,
   output logic                 packet_valid,
   output logic                 packet_sop,
   output logic                 packet_eop,
   input  logic                 out_ready,
   output logic                 err_size,
   output logic [CNT_W-1:0]     pkt_count
);

   localparam int SLOT_WORDS = 1 << PTR_IN_SZ;
   localparam logic [PTR_IN_SZ-1:0] ADDR_SRC  = '0;
   localparam logic [PTR_IN_SZ-1:0] ADDR_SIZE = PTR_IN_SZ'(2);

   typedef enum logic [2:0] {IDLE, LOAD, HDR, DATA, TAIL} state_t;

   state_t               state;
   logic [SIZE_BITS-1:0] len;
   logic [SIZE_BITS-1:0] size_len;
   logic                 size_bad;
   logic                 xfer;

   // A slot must hold SRC, DST, SIZE, len data words and the CRC word.
   assign size_len = rdata[SIZE_BITS-1:0];
   assign size_bad = (size_len == '0) || ((int'(size_len) + 4) > SLOT_WORDS);

   assign packet_valid = (state == HDR) || (state == DATA) || (state == TAIL);
   assign packet_sop   = (state == HDR) && (raddr_in == ADDR_SRC);
   assign packet_eop   = (state == TAIL);
   assign xfer         = packet_valid && out_ready;
   assign err_size     = (state == LOAD) && size_bad;
   assign rinc         = ((state == TAIL) && out_ready) || err_size;

`ifdef CRC_GEN_EN
   logic [UWIDTH-1:0] crc;

   function automatic logic [UWIDTH-1:0] crc_next(input logic [UWIDTH-1:0] c,
                                                  input logic [UWIDTH-1:0] w);
      logic [UWIDTH-1:0] r;
      r = c ^ w;
      for (int i = 0; i < UWIDTH; i++)
         r = r[UWIDTH-1] ? ((r << 1) ^ CRC_POLY) : (r << 1);
      return r;
   endfunction

   assign packet_out = (state == TAIL) ? crc : rdata;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         crc <= '0;
      else if (state == LOAD)
         crc <= '0;
      else if (xfer && (state != TAIL))
         crc <= crc_next(crc, rdata);
   end
`else
   logic unused_poly;
   assign unused_poly = ^CRC_POLY;

   // Address keeps counting through DATA, so TAIL reads the stored CRC at 3+len.
   assign packet_out = rdata;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         raddr_in  <= '0;
         len       <= '0;
         pkt_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               raddr_in <= ADDR_SIZE;
               if (!rempty)
                  state <= LOAD;
            end
            LOAD: begin
               len <= size_len;
               if (size_bad) begin
                  raddr_in <= ADDR_SIZE;
                  state    <= IDLE;
               end else begin
                  raddr_in <= ADDR_SRC;
                  state    <= HDR;
               end
            end
            HDR: begin
               if (out_ready) begin
                  raddr_in <= raddr_in + PTR_IN_SZ'(1);
                  if (raddr_in == ADDR_SIZE)
                     state <= DATA;
               end
            end
            DATA: begin
               if (out_ready) begin
                  raddr_in <= raddr_in + PTR_IN_SZ'(1);
                  len      <= len - SIZE_BITS'(1);
                  if (len == SIZE_BITS'(1))
                     state <= TAIL;
               end
            end
            TAIL: begin
               if (out_ready) begin
                  raddr_in  <= ADDR_SIZE;
                  pkt_count <= pkt_count + CNT_W'(1);
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
